ws2812_chain: RTL and testbench
===============================

WS2812_CHAIN -- requirements
Module: ws2812_chain

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, meaning number of pixels sent per frame (1..1024).
REQ-002 SHALL have parameter BITS_PER_LED, default 24, meaning bits per pixel: 24 (GRB) or 32 (GRBW).
REQ-003 SHALL have parameter T_BIT, default 125, meaning clock cycles per data bit.
REQ-004 SHALL have parameter T0H, default 40, meaning high cycles for a 0 bit.
REQ-005 SHALL have parameter T1H, default 80, meaning high cycles for a 1 bit.
REQ-006 SHALL have parameter T_RESET, default 30000, meaning low latch cycles after a frame.
REQ-007 SHALL have port i_Clock, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port i_Reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port i_Start, input, 1, a frame request, sampled only in IDLE.
REQ-010 SHALL have port i_Pixel, input, BITS_PER_LED, pixel data, MSB sent first.
REQ-011 SHALL have port i_Pixel_Valid, input, 1, meaning i_Pixel is valid.
REQ-012 SHALL have port o_Pixel_Ready, output, 1, meaning the pixel buffer is empty; a transfer occurs when Valid and Ready are both high on a clock edge.
REQ-013 SHALL have port o_Led, output, 1, the registered serial line to the LED chain.
REQ-014 SHALL have port o_Ready, output, 1, high in IDLE only.
REQ-015 SHALL have port o_Done, output, 1, a one-cycle pulse when LATCH ends.
REQ-016 SHALL have port o_Underrun, output, 1, sticky flag: at least one pixel this frame was sent as zero.

Function
REQ-017 SHALL require 0 < T0H < T1H < T_BIT and T_RESET >= 1; counter widths SHALL be $clog2 of each range.
REQ-018 SHALL implement states IDLE, SEND and LATCH; no derived or gated clocks.
REQ-019 SHALL hold a one-entry pixel buffer; o_Pixel_Ready = buffer empty, in every state including IDLE, so pixel 0 can be preloaded.
REQ-020 In IDLE with i_Start high at edge k: SHALL enter SEND at edge k, with o_Led high, o_Ready low and o_Underrun cleared after edge k.
REQ-021 At the first cycle of each pixel, the buffer SHALL move to the shift register and become empty; if the buffer is empty, SHALL load all zeros and set o_Underrun.
REQ-022 Each bit SHALL last exactly T_BIT cycles: o_Led high for T1H (bit=1) or T0H (bit=0) cycles from the bit start, then low for the rest.
REQ-023 Bits and pixels SHALL be back to back with no gap cycles; a frame is NUM_LEDS*BITS_PER_LED*T_BIT cycles.
REQ-024 After the last bit period SHALL enter LATCH, holding o_Led low for T_RESET cycles.
REQ-025 When LATCH ends, SHALL return to IDLE, pulse o_Done for one cycle and raise o_Ready in the same cycle.
REQ-026 i_Start SHALL be ignored outside IDLE; i_Start held high in IDLE SHALL start back-to-back frames, each separated by LATCH.
REQ-027 A transfer into the empty buffer SHALL be accepted even in the cycle the buffer is unloaded; a simultaneous unload and load leaves the buffer full.
REQ-028 Pixels remaining in the buffer after a frame SHALL be kept for the next frame.

Reset
REQ-029 While i_Reset is high, SHALL force: state IDLE, buffer empty, o_Led=0, o_Ready=1, o_Pixel_Ready=1, o_Done=0, o_Underrun=0, all counters 0.
REQ-030 Reset asserted mid-frame SHALL drive o_Led low immediately (asynchronously); no o_Done pulse.

Verification (NUM_LEDS=2, BITS_PER_LED=24, T_BIT=10, T0H=3, T1H=7, T_RESET=20)
REQ-031 Preload 0xA50000, start, feed 0x00FF01 -> first bit high 7 / low 3, second bit 3/7; total 480 SEND cycles; o_Done 20 cycles later; o_Underrun=0.
REQ-032 Start with no pixels supplied -> 48 bits of 3-high/7-low; o_Underrun=1 until next start.
REQ-033 Second pixel presented late (mid-pixel-0) -> accepted, no gap, o_Underrun=0.
REQ-034 i_Start pulses during SEND and LATCH -> ignored; exactly one frame and one o_Done.
REQ-035 i_Reset pulse mid-bit while o_Led is high -> o_Led=0 that cycle; IDLE, o_Ready=1; the next frame is correct.
REQ-036 BITS_PER_LED=32, NUM_LEDS=1, pixel 0x80000001 -> 32 bits (first and last long-high), o_Done correct.

Source files
------------

// File: rtl/ws2812_chain.sv
// WS2812 chain driver: serialises NUM_LEDS pixels (MSB first) as fixed-period
// high/low bit cells, then holds the line low for the latch time.
//
// state | meaning
// IDLE  | waiting for i_Start; pixel buffer may be preloaded
// SEND  | one T_BIT cell per bit, pixels back to back
// LATCH | line held low for T_RESET cycles so the chain latches
module ws2812_chain #(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int T_BIT        = 125,
  parameter int T0H          = 40,
  parameter int T1H          = 80,
  parameter int T_RESET      = 30000
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_Start,
  input  logic [BITS_PER_LED-1:0] i_Pixel,
  input  logic                    i_Pixel_Valid,
  output logic                    o_Pixel_Ready,
  output logic                    o_Led,
  output logic                    o_Ready,
  output logic                    o_Done,
  output logic                    o_Underrun
);

  localparam int TW = $clog2(T_BIT);
  localparam int BW = $clog2(BITS_PER_LED);
  localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LW = (T_RESET > 1) ? $clog2(T_RESET) : 1;

  localparam logic [TW-1:0] TMR_MAX = TW'(T_BIT - 1);
  localparam logic [TW-1:0] HI1_THR = TW'(T_BIT - T1H);
  localparam logic [TW-1:0] HI0_THR = TW'(T_BIT - T0H);
  localparam logic [BW-1:0] BIT_MAX = BW'(BITS_PER_LED - 1);
  localparam logic [PW-1:0] PIX_MAX = PW'(NUM_LEDS - 1);
  localparam logic [LW-1:0] LAT_MAX = LW'(T_RESET - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  logic [1:0]              r_State;
  logic [BITS_PER_LED-1:0] r_Buf;
  logic                    r_Buf_Full;
  logic [BITS_PER_LED-1:0] r_Shift;
  logic [TW-1:0]           r_Bit_Tmr;
  logic [BW-1:0]           r_Bit_Left;
  logic [PW-1:0]           r_Pix_Left;
  logic [LW-1:0]           r_Latch_Tmr;
  logic                    r_Led;
  logic                    r_Done;
  logic                    r_Underrun;

  logic [1:0]              w_State_Nxt;
  logic [BITS_PER_LED-1:0] w_Shift_Nxt;
  logic [BITS_PER_LED-1:0] w_Load_Data;
  logic [TW-1:0]           w_Tmr_Nxt;
  logic [BW-1:0]           w_Bit_Left_Nxt;
  logic [PW-1:0]           w_Pix_Left_Nxt;
  logic [LW-1:0]           w_Latch_Nxt;
  logic                    w_Led_Nxt;
  logic                    w_Done_Nxt;
  logic                    w_Underrun_Nxt;
  logic                    w_Unload;
  logic                    w_Accept;

  assign w_Accept    = i_Pixel_Valid && !r_Buf_Full;
  assign w_Load_Data = r_Buf_Full ? r_Buf : '0;

  always_comb begin
    w_State_Nxt    = r_State;
    w_Shift_Nxt    = r_Shift;
    w_Tmr_Nxt      = r_Bit_Tmr;
    w_Bit_Left_Nxt = r_Bit_Left;
    w_Pix_Left_Nxt = r_Pix_Left;
    w_Latch_Nxt    = r_Latch_Tmr;
    w_Done_Nxt     = 1'b0;
    w_Underrun_Nxt = r_Underrun;
    w_Unload       = 1'b0;
    case (r_State)
      IDLE: begin
        if (i_Start) begin
          w_State_Nxt    = SEND;
          w_Shift_Nxt    = w_Load_Data;
          w_Tmr_Nxt      = TMR_MAX;
          w_Bit_Left_Nxt = BIT_MAX;
          w_Pix_Left_Nxt = PIX_MAX;
          w_Underrun_Nxt = !r_Buf_Full;
          w_Unload       = 1'b1;
        end
      end
      SEND: begin
        if (r_Bit_Tmr != '0) begin
          w_Tmr_Nxt = r_Bit_Tmr - TW'(1);
        end else if (r_Bit_Left != '0) begin
          w_Tmr_Nxt      = TMR_MAX;
          w_Shift_Nxt    = {r_Shift[BITS_PER_LED-2:0], 1'b0};
          w_Bit_Left_Nxt = r_Bit_Left - BW'(1);
        end else if (r_Pix_Left != '0) begin
          // an empty buffer sends a black pixel rather than stalling the line
          w_Tmr_Nxt      = TMR_MAX;
          w_Shift_Nxt    = w_Load_Data;
          w_Bit_Left_Nxt = BIT_MAX;
          w_Pix_Left_Nxt = r_Pix_Left - PW'(1);
          w_Unload       = 1'b1;
          if (!r_Buf_Full) w_Underrun_Nxt = 1'b1;
        end else begin
          w_State_Nxt = LATCH;
          w_Tmr_Nxt   = '0;
          w_Latch_Nxt = LAT_MAX;
        end
      end
      LATCH: begin
        if (r_Latch_Tmr != '0) begin
          w_Latch_Nxt = r_Latch_Tmr - LW'(1);
        end else begin
          w_State_Nxt = IDLE;
          w_Done_Nxt  = 1'b1;
        end
      end
      default: w_State_Nxt = IDLE;
    endcase
    // line is high while the down-counter is still within the high window
    w_Led_Nxt = (w_State_Nxt == SEND) &&
                (w_Tmr_Nxt >= (w_Shift_Nxt[BITS_PER_LED-1] ? HI1_THR : HI0_THR));
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= IDLE;
      r_Buf       <= '0;
      r_Buf_Full  <= 1'b0;
      r_Shift     <= '0;
      r_Bit_Tmr   <= '0;
      r_Bit_Left  <= '0;
      r_Pix_Left  <= '0;
      r_Latch_Tmr <= '0;
      r_Led       <= 1'b0;
      r_Done      <= 1'b0;
      r_Underrun  <= 1'b0;
    end else begin
      r_State     <= w_State_Nxt;
      r_Shift     <= w_Shift_Nxt;
      r_Bit_Tmr   <= w_Tmr_Nxt;
      r_Bit_Left  <= w_Bit_Left_Nxt;
      r_Pix_Left  <= w_Pix_Left_Nxt;
      r_Latch_Tmr <= w_Latch_Nxt;
      r_Led       <= w_Led_Nxt;
      r_Done      <= w_Done_Nxt;
      r_Underrun  <= w_Underrun_Nxt;
      if (w_Unload) r_Buf_Full <= 1'b0;
      // accepting into an empty buffer wins over a same-cycle unload
      if (w_Accept) begin
        r_Buf_Full <= 1'b1;
        r_Buf      <= i_Pixel;
      end
    end
  end

  assign o_Pixel_Ready = !r_Buf_Full;
  assign o_Led         = r_Led;
  assign o_Ready       = (r_State == IDLE);
  assign o_Done        = r_Done;
  assign o_Underrun    = r_Underrun;

endmodule

// File: tb/tb_ws2812_chain.sv
// Directed bench for ws2812_chain: a 2x24-bit instance and a 1x32-bit instance
// on a short bit timing, with each bit cell's high time measured from o_Led.
module tb_ws2812_chain;
  localparam int T_BIT = 10;
  localparam int T0H = 3;
  localparam int T1H = 7;

  logic clk = 1'b0;
  logic rst;
  logic start_a, valid_a;
  logic [23:0] pix_a;
  logic pixrdy_a, led_a, ready_a, done_a, under_a;
  logic start_b, valid_b;
  logic [31:0] pix_b;
  logic pixrdy_b, led_b, ready_b, done_b, under_b;

  int errors = 0;
  int checks = 0;
  int cap_hi[64];
  bit cap_shape[64];

  always #5 clk = ~clk;

  ws2812_chain #(.NUM_LEDS(2), .BITS_PER_LED(24), .T_BIT(10), .T0H(3), .T1H(7), .T_RESET(20)) u_a (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start_a), .i_Pixel(pix_a), .i_Pixel_Valid(valid_a),
    .o_Pixel_Ready(pixrdy_a), .o_Led(led_a), .o_Ready(ready_a), .o_Done(done_a), .o_Underrun(under_a));

  ws2812_chain #(.NUM_LEDS(1), .BITS_PER_LED(32), .T_BIT(10), .T0H(3), .T1H(7), .T_RESET(20)) u_b (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start_b), .i_Pixel(pix_b), .i_Pixel_Valid(valid_b),
    .o_Pixel_Ready(pixrdy_b), .o_Led(led_b), .o_Ready(ready_b), .o_Done(done_b), .o_Underrun(under_b));

  // advance one clock; drop Valid once the handshake has completed at that edge
  task automatic tick();
    bit xa, xb;
    xa = valid_a && pixrdy_a;
    xb = valid_b && pixrdy_b;
    @(posedge clk);
    #1;
    if (xa) valid_a = 1'b0;
    if (xb) valid_b = 1'b0;
  endtask

  // record high-cycle count and high-then-low shape of each bit cell
  task automatic capture(input bit inst_b, input int nbits, input int feed_bit, input logic [23:0] feed_pix);
    logic led;
    bit seen_low;
    for (int b = 0; b < nbits; b++) begin
      if (b == feed_bit) begin
        pix_a = feed_pix;
        valid_a = 1'b1;
      end
      cap_hi[b] = 0;
      cap_shape[b] = 1'b1;
      seen_low = 1'b0;
      for (int j = 0; j < T_BIT; j++) begin
        led = inst_b ? led_b : led_a;
        if (led === 1'b1) begin
          cap_hi[b]++;
          if (seen_low) cap_shape[b] = 1'b0;
        end else begin
          seen_low = 1'b1;
          if (j == 0) cap_shape[b] = 1'b0;
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0; valid_a = 1'b0; pix_a = '0;
    start_b = 1'b0; valid_b = 1'b0; pix_b = '0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({led_a, ready_a, pixrdy_a, done_a, under_a} !== 5'b01100) begin
      errors++;
      $display("FAIL reset_outputs: got led/rdy/prdy/done/und=%b expected 01100",
               {led_a, ready_a, pixrdy_a, done_a, under_a});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({led_a, ready_a, pixrdy_a, done_a} !== 4'b0110) begin
      errors++;
      $display("FAIL idle_outputs: got %b expected 0110", {led_a, ready_a, pixrdy_a, done_a});
    end
  endtask

  task automatic test_basic_frame();
    logic [47:0] e;
    int n;
    e = {24'hA50000, 24'h00FF01};
    pix_a = 24'hA50000; valid_a = 1'b1;
    tick();
    checks++;
    if (pixrdy_a !== 1'b0 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL preload: pixel_ready=%b ready=%b expected 0 1", pixrdy_a, ready_a);
    end
    start_a = 1'b1; pix_a = 24'h00FF01; valid_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if ({led_a, ready_a, under_a} !== 3'b100) begin
      errors++;
      $display("FAIL basic_start: led/rdy/und=%b expected 100", {led_a, ready_a, under_a});
    end
    capture(1'b0, 48, -1, 24'h0);
    for (int b = 0; b < 48; b++) begin
      checks++;
      if (cap_hi[b] !== (e[47-b] ? T1H : T0H) || !cap_shape[b]) begin
        errors++;
        $display("FAIL basic_bit%0d: high=%0d shape=%0d expected high=%0d shape=1",
                 b, cap_hi[b], cap_shape[b], e[47-b] ? T1H : T0H);
      end
    end
    checks++;
    if (led_a !== 1'b0 || ready_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_latch: led=%b ready=%b expected 0 0", led_a, ready_a);
    end
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL basic_done_delay: got %0d cycles expected 20", n);
    end
    checks++;
    if (ready_a !== 1'b1 || under_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_state: ready=%b underrun=%b expected 1 0", ready_a, under_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b expected 0", done_a);
    end
  endtask

  task automatic test_underrun();
    int n;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (under_a !== 1'b1 || led_a !== 1'b1) begin
      errors++;
      $display("FAIL underrun_start: underrun=%b led=%b expected 1 1", under_a, led_a);
    end
    capture(1'b0, 48, -1, 24'h0);
    for (int b = 0; b < 48; b++) begin
      checks++;
      if (cap_hi[b] !== T0H || !cap_shape[b]) begin
        errors++;
        $display("FAIL underrun_bit%0d: high=%0d shape=%0d expected high=%0d", b, cap_hi[b], cap_shape[b], T0H);
      end
    end
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 20 || under_a !== 1'b1) begin
      errors++;
      $display("FAIL underrun_done: delay=%0d underrun=%b expected 20 1", n, under_a);
    end
    repeat (3) tick();
    checks++;
    if (under_a !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky: underrun=%b expected 1", under_a);
    end
  endtask

  task automatic test_late_pixel();
    logic [47:0] e;
    int n;
    e = {24'hC3A5F0, 24'h5A0F96};
    pix_a = 24'hC3A5F0; valid_a = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (under_a !== 1'b0) begin
      errors++;
      $display("FAIL late_underrun_clear: underrun=%b expected 0", under_a);
    end
    capture(1'b0, 48, 12, 24'h5A0F96);
    for (int b = 0; b < 48; b++) begin
      checks++;
      if (cap_hi[b] !== (e[47-b] ? T1H : T0H) || !cap_shape[b]) begin
        errors++;
        $display("FAIL late_bit%0d: high=%0d shape=%0d expected high=%0d",
                 b, cap_hi[b], cap_shape[b], e[47-b] ? T1H : T0H);
      end
    end
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 20 || under_a !== 1'b0) begin
      errors++;
      $display("FAIL late_done: delay=%0d underrun=%b expected 20 0", n, under_a);
    end
  endtask

  task automatic test_start_ignored();
    logic [47:0] e;
    int n, ndone;
    e = {24'h0F0F0F, 24'hF0F0F0};
    pix_a = 24'h0F0F0F; valid_a = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    capture(1'b0, 48, 3, 24'hF0F0F0);
    for (int b = 0; b < 48; b++) begin
      checks++;
      if (cap_hi[b] !== (e[47-b] ? T1H : T0H) || !cap_shape[b]) begin
        errors++;
        $display("FAIL ignore_bit%0d: high=%0d shape=%0d expected high=%0d",
                 b, cap_hi[b], cap_shape[b], e[47-b] ? T1H : T0H);
      end
    end
    repeat (5) tick();
    start_a = 1'b0;
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL ignore_done_delay: got %0d cycles expected 15", n);
    end
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_a === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0 || ready_a !== 1'b1 || led_a !== 1'b0) begin
      errors++;
      $display("FAIL ignore_single_frame: extra_done=%0d ready=%b led=%b expected 0 1 0", ndone, ready_a, led_a);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] e;
    int n;
    e = {24'h112233, 24'h445566};
    pix_a = 24'h112233; valid_a = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    capture(1'b0, 48, 0, 24'h445566);
    for (int b = 0; b < 48; b++) begin
      if (b == 30) ;
    end
    for (int b = 0; b < 48; b++) begin
      checks++;
      if (cap_hi[b] !== (e[47-b] ? T1H : T0H) || !cap_shape[b]) begin
        errors++;
        $display("FAIL b2b1_bit%0d: high=%0d expected %0d", b, cap_hi[b], e[47-b] ? T1H : T0H);
      end
    end
    // frame 1 is over; offer a third pixel that must stay buffered for frame 2
    pix_a = 24'h778899; valid_a = 1'b1;
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 20 || ready_a !== 1'b1 || pixrdy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: delay=%0d ready=%b pixel_ready=%b expected 20 1 0", n, ready_a, pixrdy_a);
    end
    tick();
    start_a = 1'b0;
    checks++;
    if ({led_a, ready_a, pixrdy_a, under_a} !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_restart: led/rdy/prdy/und=%b expected 1010", {led_a, ready_a, pixrdy_a, under_a});
    end
    e = {24'h778899, 24'h000000};
    capture(1'b0, 48, -1, 24'h0);
    for (int b = 0; b < 48; b++) begin
      checks++;
      if (cap_hi[b] !== (e[47-b] ? T1H : T0H) || !cap_shape[b]) begin
        errors++;
        $display("FAIL b2b2_bit%0d: high=%0d expected %0d", b, cap_hi[b], e[47-b] ? T1H : T0H);
      end
    end
    checks++;
    if (under_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_underrun: underrun=%b expected 1", under_a);
    end
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL b2b2_done: got %0d cycles expected 20", n);
    end
  endtask

  task automatic test_reset_mid_bit();
    logic [47:0] e;
    int n;
    pix_a = 24'hFFFFFF; valid_a = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    capture(1'b0, 5, -1, 24'h0);
    tick();
    checks++;
    if (led_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_led: led=%b expected 1", led_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({led_a, ready_a, pixrdy_a, done_a, under_a} !== 5'b01100) begin
      errors++;
      $display("FAIL rst_async: led/rdy/prdy/done/und=%b expected 01100", {led_a, ready_a, pixrdy_a, done_a, under_a});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_a = 1'b0;
    tick();
    checks++;
    if (done_a !== 1'b0 || ready_a !== 1'b1 || led_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: done=%b ready=%b led=%b expected 0 1 0", done_a, ready_a, led_a);
    end
    e = {24'h0000FF, 24'hFF0000};
    pix_a = 24'h0000FF; valid_a = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    capture(1'b0, 48, 0, 24'hFF0000);
    for (int b = 0; b < 48; b++) begin
      checks++;
      if (cap_hi[b] !== (e[47-b] ? T1H : T0H) || !cap_shape[b]) begin
        errors++;
        $display("FAIL rst_next_bit%0d: high=%0d expected %0d", b, cap_hi[b], e[47-b] ? T1H : T0H);
      end
    end
    n = 0;
    while (done_a !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 20 || under_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_next_done: delay=%0d underrun=%b expected 20 0", n, under_a);
    end
  endtask

  task automatic test_grbw();
    logic [31:0] e;
    int n;
    e = 32'h80000001;
    pix_b = 32'h80000001; valid_b = 1'b1;
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checks++;
    if (led_b !== 1'b1 || ready_b !== 1'b0 || pixrdy_b !== 1'b1) begin
      errors++;
      $display("FAIL grbw_start: led=%b ready=%b pixel_ready=%b expected 1 0 1", led_b, ready_b, pixrdy_b);
    end
    capture(1'b1, 32, -1, 24'h0);
    for (int b = 0; b < 32; b++) begin
      checks++;
      if (cap_hi[b] !== (e[31-b] ? T1H : T0H) || !cap_shape[b]) begin
        errors++;
        $display("FAIL grbw_bit%0d: high=%0d expected %0d", b, cap_hi[b], e[31-b] ? T1H : T0H);
      end
    end
    checks++;
    if (led_b !== 1'b0 || ready_b !== 1'b0) begin
      errors++;
      $display("FAIL grbw_latch: led=%b ready=%b expected 0 0", led_b, ready_b);
    end
    n = 0;
    while (done_b !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n !== 20 || ready_b !== 1'b1 || under_b !== 1'b0) begin
      errors++;
      $display("FAIL grbw_done: delay=%0d ready=%b underrun=%b expected 20 1 0", n, ready_b, under_b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_late_pixel();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_bit();
    test_grbw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
